multi_edge_detector: RTL and testbench

Parametrised, multi-channel successor to the single-bit edge detector. Each channel samples its `level` input on `update` strobes, passes it through a consecutive-sample glitch filter, and emits a one-clock `tick` on a qualified rising, falling or either edge, selected per channel at run time. It sits between raw button/switch/sensor inputs and the FSMs that consume their edge events.

---
 rtl/edge_det_pkg.sv | 20 ++
 rtl/edge_det_channel.sv | 82 ++++++++
 rtl/multi_edge_detector.sv | 47 ++++
 tb/tb_multi_edge_detector.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/edge_det_pkg.sv
// Shared definitions for the multi-channel edge detector: edge-select
// mode encodings, level constants and the filter counter width helper.
package edge_det_pkg;

  typedef enum logic [1:0] {
    EDGE_OFF  = 2'b00,
    EDGE_RISE = 2'b01,
    EDGE_FALL = 2'b10,
    EDGE_BOTH = 2'b11
  } edge_mode_t;

  localparam logic LOW  = 1'b0;
  localparam logic HIGH = 1'b1;

  // Counter width for a filter of the given length; never narrower than 1 bit
  function automatic int cnt_width(input int filter_len);
    return (filter_len <= 1) ? 1 : $clog2(filter_len);
  endfunction

endpackage

// File: rtl/edge_det_channel.sv
// One channel of the edge detector: consecutive-sample glitch filter,
// edge qualification against the channel mode and a one-clock tick.
// With MULTI_EDGE_DETECTOR_STICKY_EN defined, a sticky pending flag is added.
module edge_det_channel
  import edge_det_pkg::*;
#(
  parameter int   FILTER_LEN = 3,
  parameter logic INIT_LEVEL = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       update,
  input  logic       level,
  input  logic [1:0] mode,
`ifdef MULTI_EDGE_DETECTOR_STICKY_EN
  input  logic       clear,
  output logic       pending,
`endif
  output logic       filtered,
  output logic       tick
);

  localparam int CW = cnt_width(FILTER_LEN);
  localparam logic [CW-1:0] CNT_MAX = CW'(FILTER_LEN - 1);

  logic          f;
  logic [CW-1:0] cnt;
  logic          accept;
  logic          rising;
  logic          edge_hit;

  // A differing sample that completes the run of FILTER_LEN samples is
  // accepted; the new level decides whether the edge is rising or falling
  always_comb begin
    accept   = update && (level != f) && (cnt == CNT_MAX);
    rising   = (level == HIGH);
    edge_hit = 1'b0;
    if (accept) begin
      edge_hit = (mode == EDGE_BOTH)
              || (mode == EDGE_RISE && rising)
              || (mode == EDGE_FALL && !rising);
    end
  end

  // Filtered level, run counter and tick register; an agreeing sample
  // restarts the run so short glitches never reach the filtered level
  always_ff @(posedge clk) begin
    if (reset) begin
      f    <= INIT_LEVEL;
      cnt  <= '0;
      tick <= LOW;
    end else begin
      tick <= edge_hit;
      if (update) begin
        if (level == f) begin
          cnt <= '0;
        end else if (cnt == CNT_MAX) begin
          f   <= level;
          cnt <= '0;
        end else begin
          cnt <= cnt + CW'(1);
        end
      end
    end
  end

  assign filtered = f;

`ifdef MULTI_EDGE_DETECTOR_STICKY_EN
  // Sticky event flag; a new event wins over a simultaneous clear
  always_ff @(posedge clk) begin
    if (reset) begin
      pending <= LOW;
    end else if (edge_hit) begin
      pending <= HIGH;
    end else if (clear) begin
      pending <= LOW;
    end
  end
`endif

endmodule

// File: rtl/multi_edge_detector.sv
// Multi-channel debounced edge detector. Each channel filters its level on
// shared update strobes and emits a one-clock tick on the selected edge.
// Optional sticky pending flags with per-channel clear are enabled by
// defining MULTI_EDGE_DETECTOR_STICKY_EN.
module multi_edge_detector
  import edge_det_pkg::*;
#(
  parameter int   CHANNELS   = 8,
  parameter int   FILTER_LEN = 3,
  parameter logic INIT_LEVEL = 1'b1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  update,
  input  logic [CHANNELS-1:0]   level,
  input  logic [2*CHANNELS-1:0] mode,
`ifdef MULTI_EDGE_DETECTOR_STICKY_EN
  input  logic [CHANNELS-1:0]   clear,
  output logic [CHANNELS-1:0]   pending,
`endif
  output logic [CHANNELS-1:0]   filtered,
  output logic [CHANNELS-1:0]   tick,
  output logic                  any_tick
);

  for (genvar i = 0; i < CHANNELS; i++) begin : g_chan
    edge_det_channel #(
      .FILTER_LEN (FILTER_LEN),
      .INIT_LEVEL (INIT_LEVEL)
    ) u_chan (
      .clk      (clk),
      .reset    (reset),
      .update   (update),
      .level    (level[i]),
      .mode     (mode[2*i +: 2]),
`ifdef MULTI_EDGE_DETECTOR_STICKY_EN
      .clear    (clear[i]),
      .pending  (pending[i]),
`endif
      .filtered (filtered[i]),
      .tick     (tick[i])
    );
  end

  assign any_tick = |tick;

endmodule

// File: tb/tb_multi_edge_detector.sv
// Scoreboard bench for multi_edge_detector: directed start-up sequence
// followed by randomized levels, strobes, modes and resets, compared
// against a sample-window reference model.
module tb_multi_edge_detector;

  localparam int   CH   = 8;
  localparam int   FL   = 3;
  localparam logic INIT = 1'b1;

  logic            clk;
  logic            reset;
  logic            update;
  logic [CH-1:0]   level;
  logic [2*CH-1:0] mode;
  logic [CH-1:0]   clear;
  logic [CH-1:0]   pending;
  logic [CH-1:0]   filtered;
  logic [CH-1:0]   tick;
  logic            any_tick;

  multi_edge_detector #(
    .CHANNELS   (CH),
    .FILTER_LEN (FL),
    .INIT_LEVEL (INIT)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .update   (update),
    .level    (level),
    .mode     (mode),
`ifdef MULTI_EDGE_DETECTOR_STICKY_EN
    .clear    (clear),
    .pending  (pending),
`endif
    .filtered (filtered),
    .tick     (tick),
    .any_tick (any_tick)
  );

`ifndef MULTI_EDGE_DETECTOR_STICKY_EN
  assign pending = '0;
`endif

  typedef struct packed {
    logic [CH-1:0] filt;
    logic [CH-1:0] tick;
    logic          any;
    logic [CH-1:0] pend;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  bit   model_f[CH];
  bit   model_pend[CH];
  bit   hist[CH][$];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act !== req)
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, req, $time);
    else
      n_pass++;
  endtask

  // Drive one clock of inputs and push what the outputs must be after it.
  // The model accepts a new level once the last FL strobed samples all
  // differ from the current filtered level.
  task automatic applyStimulus(input logic rst, input logic upd, input logic [CH-1:0] lvl,
                               input logic [2*CH-1:0] md, input logic [CH-1:0] clr);
    exp_t     e;
    bit       hit;
    bit       all_diff;
    bit [1:0] m;
    @(negedge clk);
    reset  = rst;
    update = upd;
    level  = lvl;
    mode   = md;
    clear  = clr;
    e = '0;
    for (int i = 0; i < CH; i++) begin
      hit = 1'b0;
      if (rst) begin
        model_f[i]    = INIT;
        model_pend[i] = 1'b0;
        hist[i].delete();
      end else begin
        if (upd) begin
          hist[i].push_back(lvl[i]);
          if (hist[i].size() > FL) void'(hist[i].pop_front());
          all_diff = (hist[i].size() == FL);
          foreach (hist[i][k]) if (hist[i][k] == model_f[i]) all_diff = 1'b0;
          if (all_diff) begin
            model_f[i] = lvl[i];
            m = md[2*i +: 2];
            hit = (m == 2'd3) || (m == 2'd1 && lvl[i]) || (m == 2'd2 && !lvl[i]);
          end
        end
        if (hit) model_pend[i] = 1'b1;
        else if (clr[i]) model_pend[i] = 1'b0;
      end
      e.filt[i] = model_f[i];
      e.tick[i] = hit;
`ifdef MULTI_EDGE_DETECTOR_STICKY_EN
      e.pend[i] = model_pend[i];
`endif
    end
    e.any = |e.tick;
    exp_q.push_back(e);
  endtask

  // Monitor: compare each clock's outputs against the scoreboard head
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        checkOutput("filtered", 64'(filtered), 64'(e.filt));
        checkOutput("tick",     64'(tick),     64'(e.tick));
        checkOutput("any_tick", 64'(any_tick), 64'(e.any));
        checkOutput("pending",  64'(pending),  64'(e.pend));
      end
    end
  end

  // Stimulus: directed start-up and filter cases, then randomized traffic
  initial begin
    logic [2*CH-1:0] md;
    logic [CH-1:0]   tgt;
    logic [CH-1:0]   lvl;
    logic [CH-1:0]   glitch;
    logic [CH-1:0]   clr;
    int              wait_cyc;
    reset  = 1'b1;
    update = 1'b0;
    level  = '1;
    mode   = '0;
    clear  = '0;

    // ch0 rise, ch1 both, ch2 fall, ch3 off, ch4..7 both
    md = 16'hFF2D;
    repeat (3) applyStimulus(1'b1, 1'b1, '1, md, '0);
    repeat (10) applyStimulus(1'b0, 1'b1, '1, md, '0);
    repeat (4) begin
      applyStimulus(1'b0, 1'b1, 8'hF2, md, '0);
      applyStimulus(1'b0, 1'b0, 8'hFF, md, '0);
    end
    repeat (2) applyStimulus(1'b0, 1'b1, 8'hF0, md, '0);
    repeat (3) applyStimulus(1'b0, 1'b1, 8'hF2, md, '0);
    repeat (4) applyStimulus(1'b0, 1'b1, 8'hFF, md, 8'h10);
    repeat (2) applyStimulus(1'b0, 1'b1, 8'h00, md, '0);
    applyStimulus(1'b1, 1'b1, 8'h00, md, '0);
    repeat (4) applyStimulus(1'b0, 1'b1, 8'h00, md, 8'h10);
    repeat (4) applyStimulus(1'b0, 1'b1, 8'hFF, md, '0);

    tgt = '1;
    for (int n = 0; n < 3000; n++) begin
      for (int i = 0; i < CH; i++) begin
        if ($urandom_range(11) == 0) tgt[i] = ~tgt[i];
        glitch[i] = ($urandom_range(9) == 0);
        clr[i]    = ($urandom_range(3) == 0);
      end
      if ($urandom_range(19) == 0) md = 16'($urandom);
      lvl = tgt ^ glitch;
      applyStimulus(($urandom_range(149) == 0), ($urandom_range(3) != 0), lvl, md, clr);
    end

    wait_cyc = 0;
    while (exp_q.size() > 0 && wait_cyc < 10) begin
      @(posedge clk);
      wait_cyc++;
    end
    #2;
    checkOutput("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
